// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state codes, opcodes and control-field encodings for the multicycle MIPS controller
package multicycle_control_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;
endpackage

// File: rtl/multicycle_control_output_decode.sv
// multicycle_control_output_decode: Moore state -> datapath control vector
//   reset     in   forces every control to 0
//   state     in   current FSM state
//   mem_ready in   gates IRWrite/PCWrite in FETCH
//   ctrl      out  control vector
module multicycle_control_output_decode
    import multicycle_control_pkg::*;
(
    input  logic   reset,
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            default: ctrl = '0;
        endcase
        if (reset) ctrl = '0;
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing a multicycle MIPS datapath (R-type, LW, SW, BEQ)
//   clock/reset   sync active-high reset
//   Op, Zero      opcode and ALU zero flag (Zero is consumed by the datapath via PCWriteCond)
//   mem_ready     memory handshake, honoured in FETCH/MEMRD/MEMWR only
//   PCWrite..PCSource  per-cycle datapath controls
//   state, retired, illegal_op  debug state, retired count, sticky bad-opcode flag
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [5:0]           Op,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic [3:0]           state,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 illegal_op
);
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 illegal_op_q, illegal_op_d;
    logic                 retire;
    logic                 unused_zero;
    ctrl_t                ctrl;
    assign unused_zero = Zero;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_FETCH;
            retired_q    <= '0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            retired_q    <= retired_d;
            illegal_op_q <= illegal_op_d;
        end
    end
    always_comb begin
        state_d      = S_FETCH;
        retire       = 1'b0;
        illegal_op_d = illegal_op_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  retire  = 1'b1;
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
                retire  = mem_ready;
            end
            S_REXEC:  state_d = S_RWB;
            S_RWB:    retire  = 1'b1;
            S_BEQ:    retire  = 1'b1;
            default:  state_d = S_FETCH;
        endcase
        retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    end
    multicycle_control_output_decode u_dec (
        .reset     (reset),
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign state       = state_q;
    assign retired     = retired_q;
    assign illegal_op  = illegal_op_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Op = 6'd0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic [15:0] retired;
    logic        illegal_op;
    logic        s_pcw, s_pwc, s_iord, s_mr, s_mw, s_irw, s_m2r, s_rd, s_rw, s_sa;
    logic [1:0]  s_sb, s_op, s_ps;
    logic [3:0]  s_state;
    logic [3:0]  s_retired;
    logic        s_ill;
    int          errors = 0;
    int          checks = 0;
    wire  [15:0] ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                        RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
    multicycle_control dut (
        .clock(clock), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .retired(retired), .illegal_op(illegal_op)
    );
    multicycle_control #(.CNT_WIDTH(4)) dut_small (
        .clock(clock), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(s_pcw), .PCWriteCond(s_pwc), .IorD(s_iord), .MemRead(s_mr),
        .MemWrite(s_mw), .IRWrite(s_irw), .MemtoReg(s_m2r), .RegDst(s_rd),
        .RegWrite(s_rw), .ALUSrcA(s_sa), .ALUSrcB(s_sb), .ALUOp(s_op),
        .PCSource(s_ps), .state(s_state), .retired(s_retired), .illegal_op(s_ill)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    initial begin
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'h0000);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        Op = 6'b000000;
        #1;
        chk("fetch_ctl", 32'(ctl), 32'h9410);
        tick(); chk("r_s1", 32'(state), 32'd1); chk("r_dec_ctl", 32'(ctl), 32'h0030);
        tick(); chk("r_s6", 32'(state), 32'd6); chk("r_exec_ctl", 32'(ctl), 32'h0048);
        tick(); chk("r_s7", 32'(state), 32'd7); chk("r_wb_ctl", 32'(ctl), 32'h0180);
        tick(); chk("r_s0", 32'(state), 32'd0); chk("r_retired", 32'(retired), 32'd1);
        Op = 6'b100011;
        tick(); chk("lw_s1", 32'(state), 32'd1);
        tick(); chk("lw_s2", 32'(state), 32'd2); chk("lw_adr_ctl", 32'(ctl), 32'h0060);
        tick(); chk("lw_s3", 32'(state), 32'd3); chk("lw_rd_ctl", 32'(ctl), 32'h3000);
        mem_ready = 1'b0;
        tick(); chk("lw_wait1", 32'(state), 32'd3);
        tick(); chk("lw_wait2", 32'(state), 32'd3);
        mem_ready = 1'b1;
        tick(); chk("lw_s4", 32'(state), 32'd4); chk("lw_wb_ctl", 32'(ctl), 32'h0280);
        chk("lw_not_yet", 32'(retired), 32'd1);
        tick(); chk("lw_s0", 32'(state), 32'd0); chk("lw_retired", 32'(retired), 32'd2);
        mem_ready = 1'b0;
        #1;
        chk("fetch_wait_ctl", 32'(ctl), 32'h1010);
        tick(); chk("fetch_wait_state", 32'(state), 32'd0);
        mem_ready = 1'b1;
        Op = 6'b000100;
        Zero = 1'b1;
        tick(); chk("beq1_s1", 32'(state), 32'd1);
        tick(); chk("beq1_s8", 32'(state), 32'd8); chk("beq1_ctl", 32'(ctl), 32'h4045);
        tick(); chk("beq1_retired", 32'(retired), 32'd3);
        Zero = 1'b0;
        tick();
        tick(); chk("beq0_s8", 32'(state), 32'd8); chk("beq0_ctl", 32'(ctl), 32'h4045);
        tick(); chk("beq0_s0", 32'(state), 32'd0); chk("beq0_retired", 32'(retired), 32'd4);
        Op = 6'b111111;
        tick(); chk("ill_s1", 32'(state), 32'd1);
        tick(); chk("ill_s0", 32'(state), 32'd0); chk("ill_flag", 32'(illegal_op), 32'd1);
        chk("ill_retired", 32'(retired), 32'd4);
        Op = 6'b000100;
        tick(); tick(); tick();
        chk("ill_sticky", 32'(illegal_op), 32'd1);
        chk("post_ill_retired", 32'(retired), 32'd5);
        Op = 6'b101011;
        tick(); chk("sw_s1", 32'(state), 32'd1);
        tick(); chk("sw_s2", 32'(state), 32'd2);
        mem_ready = 1'b0;
        tick(); chk("sw_s5", 32'(state), 32'd5); chk("sw_ctl", 32'(ctl), 32'h2800);
        tick(); chk("sw_wait", 32'(state), 32'd5); chk("sw_retired_wait", 32'(retired), 32'd5);
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("sw_rst_ctl", 32'(ctl), 32'h0000);
        tick();
        chk("sw_rst_state", 32'(state), 32'd0);
        chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("sw_rst_retired", 32'(retired), 32'd0);
        chk("sw_rst_illegal", 32'(illegal_op), 32'd0);
        reset = 1'b0;
        Op = 6'b000100;
        for (int i = 0; i < 15; i++) begin
            tick(); tick(); tick();
        end
        chk("wrap_pre_small", 32'(s_retired), 32'd15);
        chk("wrap_pre_big", 32'(retired), 32'd15);
        tick(); tick(); tick();
        chk("wrap_small", 32'(s_retired), 32'd0);
        chk("wrap_big", 32'(retired), 32'd16);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
